// File: rtl/prng_stream_checker.sv
// Receive-side checker for the 16-bit PRNG word stream.
// Regenerates expected words from a 4-bit LFSR seed and compares them.
module prng_stream_checker #(
    parameter int NUM_WORDS = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loadseed,
    input  logic [3:0]       seed,
    input  logic             start,
    input  logic             chain,
    input  logic             in_valid,
    input  logic [15:0]      in_word,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_bad_idx,
    output logic [15:0]      first_bad_exp
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] GEN  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] CMP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state;
    logic [3:0]       seed_q;
    logic [3:0]       lfsr;
    logic [1:0]       gcnt;
    logic [15:0]      exp_q;
    logic [15:0]      rx_q;
    logic [CNT_W-1:0] wcnt;

    logic             mismatch;
    logic [CNT_W-1:0] err_nxt;
    logic [CNT_W-1:0] wcnt_nxt;
    logic             last;

    function automatic logic [3:0] lfsr_step(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[0]};
    endfunction

    // Handshake and run status decoded from state alone
    always_comb begin
        in_ready = (state == WAIT);
        busy     = (state == GEN) || (state == WAIT) || (state == CMP);
    end

    // Compare result, saturating error count and end-of-run detect
    always_comb begin
        mismatch = (rx_q != exp_q);
        err_nxt  = err_count;
        if (mismatch && !(&err_count))
            err_nxt = err_count + CNT_W'(1);
        wcnt_nxt = wcnt + CNT_W'(1);
        last     = (wcnt_nxt == CNT_W'(NUM_WORDS));
    end

    // Main control: seed load, word generation, handshake and compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            seed_q        <= 4'b1010;
            lfsr          <= 4'b1010;
            gcnt          <= '0;
            exp_q         <= '0;
            rx_q          <= '0;
            wcnt          <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_bad_idx <= '0;
            first_bad_exp <= '0;
        end else if (loadseed) begin
            state         <= IDLE;
            seed_q        <= seed;
            lfsr          <= seed;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_bad_idx <= '0;
            first_bad_exp <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= GEN;
                        lfsr          <= seed_q;
                        gcnt          <= '0;
                        wcnt          <= '0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_bad_idx <= '0;
                        first_bad_exp <= '0;
                    end
                end
                GEN: begin
                    exp_q <= {exp_q[11:0], lfsr};
                    lfsr  <= lfsr_step(lfsr);
                    gcnt  <= gcnt + 2'd1;
                    if (gcnt == 2'd3)
                        state <= WAIT;
                end
                WAIT: begin
                    if (in_valid) begin
                        rx_q  <= in_word;
                        state <= CMP;
                    end
                end
                CMP: begin
                    err_count <= err_nxt;
                    if (mismatch && (err_count == '0)) begin
                        first_bad_idx <= wcnt;
                        first_bad_exp <= exp_q;
                    end
                    wcnt <= wcnt_nxt;
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        // lfsr already holds the state after the 4th step
                        lfsr  <= chain ? lfsr : seed_q;
                        gcnt  <= '0;
                        state <= GEN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_stream_checker.sv
// Directed bench for prng_stream_checker.
// Table-driven two-word runs plus hand-written corner sequences.
module tb_prng_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        loadseed;
    logic [3:0]  seed;
    logic        start;
    logic        chain;
    logic        in_valid;
    logic [15:0] in_word;

    logic        d1_ready, d1_busy, d1_done, d1_pass;
    logic [7:0]  d1_err, d1_idx;
    logic [15:0] d1_exp;
    logic        d2_ready, d2_busy, d2_done, d2_pass;
    logic [7:0]  d2_err, d2_idx;
    logic [15:0] d2_exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prng_stream_checker #(.NUM_WORDS(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .loadseed(loadseed), .seed(seed),
        .start(start), .chain(chain), .in_valid(in_valid),
        .in_word(in_word), .in_ready(d1_ready), .busy(d1_busy),
        .done(d1_done), .pass(d1_pass), .err_count(d1_err),
        .first_bad_idx(d1_idx), .first_bad_exp(d1_exp)
    );

    prng_stream_checker #(.NUM_WORDS(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .loadseed(loadseed), .seed(seed),
        .start(start), .chain(chain), .in_valid(in_valid),
        .in_word(in_word), .in_ready(d2_ready), .busy(d2_busy),
        .done(d2_done), .pass(d2_pass), .err_count(d2_err),
        .first_bad_idx(d2_idx), .first_bad_exp(d2_exp)
    );

    typedef struct {
        logic [3:0]  seed;
        logic        chain;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        pass;
        logic [7:0]  err;
        logic [7:0]  idx;
        logic [15:0] fexp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] s);
        loadseed = 1'b1;
        seed     = s;
        tick();
        loadseed = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_word  = w;
        while (!d2_ready && n < 20) begin
            tick();
            n++;
        end
        if (!d2_ready)
            check("ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!d2_done && n < 60) begin
            tick();
            n++;
        end
        check("done_reached", 32'(d2_done), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(d2_busy),  32'd0);
        check({tag, "_ready"}, 32'(d2_ready), 32'd0);
        check({tag, "_done"},  32'(d2_done),  32'd0);
        check({tag, "_pass"},  32'(d2_pass),  32'd0);
        check({tag, "_err"},   32'(d2_err),   32'd0);
        check({tag, "_idx"},   32'(d2_idx),   32'd0);
        check({tag, "_fexp"},  32'(d2_exp),   32'd0);
    endtask

    initial begin
        vecs[0] = '{4'hA, 1'b1, 16'hA5B6, 16'hC924, 1'b1, 8'd0, 8'd0, 16'h0000};
        vecs[1] = '{4'hA, 1'b1, 16'hA5B6, 16'hC925, 1'b0, 8'd1, 8'd1, 16'hC924};
        vecs[2] = '{4'hA, 1'b0, 16'hA5B6, 16'hA5B6, 1'b1, 8'd0, 8'd0, 16'h0000};
        vecs[3] = '{4'hA, 1'b0, 16'hA5B6, 16'hC924, 1'b0, 8'd1, 8'd1, 16'hA5B6};
        vecs[4] = '{4'h0, 1'b1, 16'h0000, 16'h0000, 1'b1, 8'd0, 8'd0, 16'h0000};
        vecs[5] = '{4'h0, 1'b1, 16'h1234, 16'h0000, 1'b0, 8'd1, 8'd0, 16'h0000};
        vecs[6] = '{4'h1, 1'b1, 16'h137F, 16'hEDA5, 1'b1, 8'd0, 8'd0, 16'h0000};
        vecs[7] = '{4'h1, 1'b1, 16'h0000, 16'hEDA4, 1'b0, 8'd2, 8'd0, 16'h137F};

        rst_n    = 1'b0;
        loadseed = 1'b0;
        seed     = 4'h0;
        start    = 1'b0;
        chain    = 1'b1;
        in_valid = 1'b0;
        in_word  = 16'h0000;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // default seed, single-word checker and two-word chained checker
        pulse_start();
        check("busy_after_start", 32'(d2_busy), 32'd1);
        send(16'hA5B6);
        tick();
        check("nw1_done", 32'(d1_done), 32'd1);
        check("nw1_pass", 32'(d1_pass), 32'd1);
        check("nw1_err",  32'(d1_err),  32'd0);
        check("nw1_busy", 32'(d1_busy), 32'd0);
        send(16'hC924);
        wait_done();
        check("first_pass", 32'(d2_pass), 32'd1);

        for (int i = 0; i < 8; i++) begin
            chain = vecs[i].chain;
            do_load(vecs[i].seed);
            pulse_start();
            send(vecs[i].w0);
            send(vecs[i].w1);
            wait_done();
            check($sformatf("v%0d_pass", i), 32'(d2_pass), 32'(vecs[i].pass));
            check($sformatf("v%0d_err", i),  32'(d2_err),  32'(vecs[i].err));
            check($sformatf("v%0d_idx", i),  32'(d2_idx),  32'(vecs[i].idx));
            check($sformatf("v%0d_fexp", i), 32'(d2_exp),  32'(vecs[i].fexp));
            check($sformatf("v%0d_busy", i), 32'(d2_busy), 32'd0);
        end

        // in_valid held through GEN is not accepted until WAIT
        chain = 1'b1;
        do_load(4'hA);
        pulse_start();
        in_valid = 1'b1;
        in_word  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("gen_ready%0d", i), 32'(d2_ready), 32'd0);
            tick();
        end
        check("wait_ready", 32'(d2_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("cmp_ready", 32'(d2_ready), 32'd0);
        tick();
        check("mid_err",  32'(d2_err), 32'd1);
        check("mid_fexp", 32'(d2_exp), 32'hA5B6);
        tick();
        // loadseed mid-GEN aborts and clears
        do_load(4'h0);
        check_zero("abort");
        pulse_start();
        send(16'h0000);
        send(16'h0000);
        wait_done();
        check("zero_pass", 32'(d2_pass), 32'd1);
        check("zero_err",  32'(d2_err),  32'd0);

        // async reset mid-WAIT with non-zero status
        pulse_start();
        send(16'h1111);
        begin
            int n = 0;
            while (!d2_ready && n < 20) begin
                tick();
                n++;
            end
        end
        check("pre_rst_ready", 32'(d2_ready), 32'd1);
        check("pre_rst_err",   32'(d2_err),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send(16'hA5B6);
        tick();
        check("post_rst_nw1_pass", 32'(d1_pass), 32'd1);
        send(16'hC924);
        wait_done();
        check("post_rst_pass", 32'(d2_pass), 32'd1);
        check("post_rst_err",  32'(d2_err),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prng_stream_checker.md
Name: prng_stream_checker

Overview:
- Receive-side checker for the 16-bit PRNG word generator. It regenerates the expected word sequence from a 4-bit seed using the identical LFSR and nibble-packing rule.
- Compares each word received over a valid/ready handshake and reports pass/fail, an error count and the first mismatch.
- Sits at the consumer end of the PRNG path: the FHE noise/mask sampling input, and the self-test harness.

Parameters:
- NUM_WORDS, 4, number of words checked per run (1..255).
- CNT_W, 8, width of err_count and the word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- loadseed  in  1  capture seed, abort any run, return to IDLE.
- seed  in  4  seed; 4'b1010 is the reset default.
- start  in  1  begin a run from IDLE.
- chain  in  1  1: next word's seed = LFSR state after previous word; 0: every word restarts from loaded seed.
- in_valid  in  1  received word valid.
- in_word  in  16  received PRNG word.
- in_ready  out  1  checker accepts a word this cycle.
- busy  out  1  run in progress.
- done  out  1  run complete; sticky until start, loadseed or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  CNT_W  mismatching words this run; saturates at all-ones.
- first_bad_idx  out  CNT_W  index of first mismatching word; 0 if none.
- first_bad_exp  out  16  expected value at first mismatch; 0 if none.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - seed register=4'b1010, LFSR=4'b1010.
  - All outputs 0.
- LFSR step: fb=l[3]^l[0]; l_next={l[2:0],fb}.
- Expected word: 4 nibbles s0..s3, where s0 = the current LFSR and each subsequent nibble is one LFSR step later. exp={s0,s1,s2,s3} (s0 in bits 15:12).
- State s4 is the LFSR after the 4th step.
- Precedence: rst_n > loadseed > start > handshake.
- loadseed in any state:
  - seed register and LFSR take seed; state=IDLE.
  - done, pass, err_count, first_bad_* cleared.
  - A word offered that cycle is not accepted.
- IDLE: start=1 -> GEN.
  - Clears done, err_count, first_bad_*, word counter.
  - LFSR = seed register.
- GEN:
  - 4 cycles, one nibble per cycle shifted into exp (exp=(exp<<4)|l), then the LFSR steps.
  - Then -> WAIT. busy=1.
- WAIT: in_ready=1 (combinational from state only). On in_valid&in_ready, in_word is latched -> CMP.
- CMP, 1 cycle:
  - Mismatch: err_count++ (saturating).
  - On the first mismatch, first_bad_idx=word counter and first_bad_exp=exp.
  - Word counter++.
  - If counter reaches NUM_WORDS -> DONE. Otherwise LFSR = chain ? s4 : seed register, then -> GEN.
- DONE:
  - done=1, pass=(err_count==0), busy=0.
  - Remains in DONE; start -> re-run as from IDLE.
- start is ignored while busy.
- in_valid is ignored outside WAIT.
- Per-word latency: 4 GEN cycles + handshake cycle + 1 CMP cycle.
- Minimum run length: NUM_WORDS*6 cycles.
- Seed 4'b0000: all words expected 0x0000. Legal; no lock-up detection.
- chain is sampled at each CMP cycle.

Test Plan:
- Default seed after reset, start, NUM_WORDS=1, send 0xA5B6 -> done=1, pass=1, err_count=0.
- Seed 1010, chain=1, NUM_WORDS=2, send 0xA5B6 then 0xC924 -> pass=1.
- Same as above but 2nd word 0xC925 -> pass=0, err_count=1, first_bad_idx=1, first_bad_exp=0xC924.
- chain=0, NUM_WORDS=2, send 0xA5B6 twice -> pass=1.
- Same with 0xC924 as 2nd word -> err_count=1.
- in_valid held high during GEN -> no acceptance until WAIT. loadseed=1, seed=4'b0000 mid-GEN -> IDLE with counters cleared; start, send 0x0000 -> pass=1.
- rst_n low mid-WAIT -> all outputs 0 immediately (async), in_ready=0. After release, the seed register reads 4'b1010 (start and 0xA5B6 pass).
